// File: rtl/baccarat_if.sv
// rtl/baccarat_if.sv - load strobes from the control FSM and card/score results back
interface baccarat_if;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic [3:0] pcard1;
    logic [3:0] pcard2;
    logic [3:0] pcard3;
    logic [3:0] dcard1;
    logic [3:0] dcard2;
    logic [3:0] dcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] deal_card;

    modport master (
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        input  pscore, dscore, deal_card
    );

    modport slave (
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        output pscore, dscore, deal_card
    );
endinterface

// File: rtl/baccarat_datapath.sv
// rtl/baccarat_datapath.sv - dealer counter, six card slots and combinational hand scores
module baccarat_datapath #(
    parameter logic [3:0] SEED = 4'd1
) (
    input  logic       slow_clock,
    input  logic       reset,
    baccarat_if.slave  bus
);

    logic [3:0] deal_q;
    logic [3:0] pcard1_q;
    logic [3:0] pcard2_q;
    logic [3:0] pcard3_q;
    logic [3:0] dcard1_q;
    logic [3:0] dcard2_q;
    logic [3:0] dcard3_q;

    // Ranks 10..13 count as zero; an empty slot (0) also counts as zero.
    function automatic logic [4:0] card_value(input logic [3:0] rank);
        return (rank <= 4'd9) ? {1'b0, rank} : 5'd0;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] sum);
        logic [4:0] r;
        if (sum >= 5'd20)
            r = sum - 5'd20;
        else if (sum >= 5'd10)
            r = sum - 5'd10;
        else
            r = sum;
        return r[3:0];
    endfunction

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            deal_q   <= SEED;
            pcard1_q <= 4'd0;
            pcard2_q <= 4'd0;
            pcard3_q <= 4'd0;
            dcard1_q <= 4'd0;
            dcard2_q <= 4'd0;
            dcard3_q <= 4'd0;
        end else begin
            // >= rather than == so an out-of-range value still falls back into 1..13
            deal_q <= (deal_q >= 4'd13 || deal_q == 4'd0) ? 4'd1 : deal_q + 4'd1;
            if (bus.load_pcard1) pcard1_q <= deal_q;
            if (bus.load_pcard2) pcard2_q <= deal_q;
            if (bus.load_pcard3) pcard3_q <= deal_q;
            if (bus.load_dcard1) dcard1_q <= deal_q;
            if (bus.load_dcard2) dcard2_q <= deal_q;
            if (bus.load_dcard3) dcard3_q <= deal_q;
        end
    end

    assign bus.deal_card = deal_q;
    assign bus.pcard1    = pcard1_q;
    assign bus.pcard2    = pcard2_q;
    assign bus.pcard3    = pcard3_q;
    assign bus.dcard1    = dcard1_q;
    assign bus.dcard2    = dcard2_q;
    assign bus.dcard3    = dcard3_q;

    // Scores are pure combinational so the FSM sees them in the cycle after the load.
    assign bus.pscore = mod10(card_value(pcard1_q) + card_value(pcard2_q) + card_value(pcard3_q));
    assign bus.dscore = mod10(card_value(dcard1_q) + card_value(dcard2_q) + card_value(dcard3_q));

endmodule

// File: tb/tb_baccarat_datapath.sv
// tb/tb_baccarat_datapath.sv - directed checks of the baccarat card/score datapath
module tb_baccarat_datapath;

    logic slow_clock = 1'b0;
    logic reset      = 1'b0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    baccarat_if bus ();

    baccarat_datapath #(.SEED(4'd1)) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic clear_loads();
        bus.load_pcard1 = 1'b0;
        bus.load_pcard2 = 1'b0;
        bus.load_pcard3 = 1'b0;
        bus.load_dcard1 = 1'b0;
        bus.load_dcard2 = 1'b0;
        bus.load_dcard3 = 1'b0;
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        clear_loads();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.load_pcard1 = 1'b1; bus.load_pcard2 = 1'b1; bus.load_pcard3 = 1'b1;
        bus.load_dcard1 = 1'b1; bus.load_dcard2 = 1'b1; bus.load_dcard3 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_loads();
        n_checks++; if (bus.pcard1 !== 4'd0) begin n_fail++; $display("FAIL reset_pcard1 got %0d exp 0", bus.pcard1); end
        n_checks++; if (bus.pcard2 !== 4'd0) begin n_fail++; $display("FAIL reset_pcard2 got %0d exp 0", bus.pcard2); end
        n_checks++; if (bus.pcard3 !== 4'd0) begin n_fail++; $display("FAIL reset_pcard3 got %0d exp 0", bus.pcard3); end
        n_checks++; if (bus.dcard1 !== 4'd0) begin n_fail++; $display("FAIL reset_dcard1 got %0d exp 0", bus.dcard1); end
        n_checks++; if (bus.dcard2 !== 4'd0) begin n_fail++; $display("FAIL reset_dcard2 got %0d exp 0", bus.dcard2); end
        n_checks++; if (bus.dcard3 !== 4'd0) begin n_fail++; $display("FAIL reset_dcard3 got %0d exp 0", bus.dcard3); end
        n_checks++; if (bus.pscore !== 4'd0) begin n_fail++; $display("FAIL reset_pscore got %0d exp 0", bus.pscore); end
        n_checks++; if (bus.dscore !== 4'd0) begin n_fail++; $display("FAIL reset_dscore got %0d exp 0", bus.dscore); end
        n_checks++; if (bus.deal_card !== 4'd1) begin n_fail++; $display("FAIL reset_deal got %0d exp 1", bus.deal_card); end
    endtask

    task automatic test_first_card();
        do_reset();
        bus.load_pcard1 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.pcard1 !== 4'd1) begin n_fail++; $display("FAIL first_pcard1 got %0d exp 1", bus.pcard1); end
        n_checks++; if (bus.pscore !== 4'd1) begin n_fail++; $display("FAIL first_pscore got %0d exp 1", bus.pscore); end
        n_checks++; if (bus.deal_card !== 4'd2) begin n_fail++; $display("FAIL first_deal got %0d exp 2", bus.deal_card); end
    endtask

    task automatic test_two_cards();
        do_reset();
        idle(2);
        bus.load_pcard1 = 1'b1;
        tick();
        bus.load_pcard1 = 1'b0;
        bus.load_pcard2 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.pcard1 !== 4'd3) begin n_fail++; $display("FAIL two_pcard1 got %0d exp 3", bus.pcard1); end
        n_checks++; if (bus.pcard2 !== 4'd4) begin n_fail++; $display("FAIL two_pcard2 got %0d exp 4", bus.pcard2); end
        n_checks++; if (bus.pscore !== 4'd7) begin n_fail++; $display("FAIL two_pscore got %0d exp 7", bus.pscore); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_deal;
        do_reset();
        idle(11);
        bus.load_dcard1 = 1'b1;
        tick();
        bus.load_dcard1 = 1'b0;
        bus.load_dcard2 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.dcard1 !== 4'd12) begin n_fail++; $display("FAIL wrap_dcard1 got %0d exp 12", bus.dcard1); end
        n_checks++; if (bus.dcard2 !== 4'd13) begin n_fail++; $display("FAIL wrap_dcard2 got %0d exp 13", bus.dcard2); end
        n_checks++; if (bus.dscore !== 4'd0) begin n_fail++; $display("FAIL wrap_dscore got %0d exp 0", bus.dscore); end
        n_checks++; if (bus.deal_card !== 4'd1) begin n_fail++; $display("FAIL wrap_deal got %0d exp 1", bus.deal_card); end
        exp_deal = 4'd1;
        for (int i = 0; i < 30; i++) begin
            tick();
            exp_deal = (exp_deal == 4'd13) ? 4'd1 : exp_deal + 4'd1;
            n_checks++;
            if (bus.deal_card !== exp_deal) begin
                n_fail++;
                $display("FAIL counter_seq step %0d got %0d exp %0d", i, bus.deal_card, exp_deal);
            end
        end
    endtask

    task automatic test_third_card();
        do_reset();
        idle(7);
        bus.load_pcard1 = 1'b1;
        tick();
        bus.load_pcard1 = 1'b0;
        bus.load_pcard2 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.pscore !== 4'd7) begin n_fail++; $display("FAIL third_pscore2 got %0d exp 7", bus.pscore); end
        idle(10);
        bus.load_pcard3 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.pcard1 !== 4'd8) begin n_fail++; $display("FAIL third_pcard1 got %0d exp 8", bus.pcard1); end
        n_checks++; if (bus.pcard2 !== 4'd9) begin n_fail++; $display("FAIL third_pcard2 got %0d exp 9", bus.pcard2); end
        n_checks++; if (bus.pcard3 !== 4'd7) begin n_fail++; $display("FAIL third_pcard3 got %0d exp 7", bus.pcard3); end
        n_checks++; if (bus.pscore !== 4'd4) begin n_fail++; $display("FAIL third_pscore got %0d exp 4", bus.pscore); end
        n_checks++; if (bus.dscore !== 4'd0) begin n_fail++; $display("FAIL third_dscore got %0d exp 0", bus.dscore); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        idle(4);
        bus.load_pcard1 = 1'b1;
        bus.load_dcard1 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.pcard1 !== 4'd5) begin n_fail++; $display("FAIL simul_pcard1 got %0d exp 5", bus.pcard1); end
        n_checks++; if (bus.dcard1 !== 4'd5) begin n_fail++; $display("FAIL simul_dcard1 got %0d exp 5", bus.dcard1); end
        n_checks++; if (bus.pscore !== 4'd5) begin n_fail++; $display("FAIL simul_pscore got %0d exp 5", bus.pscore); end
        n_checks++; if (bus.dscore !== 4'd5) begin n_fail++; $display("FAIL simul_dscore got %0d exp 5", bus.dscore); end
    endtask

    task automatic test_overwrite();
        do_reset();
        bus.load_dcard3 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.dcard3 !== 4'd1) begin n_fail++; $display("FAIL over_first got %0d exp 1", bus.dcard3); end
        idle(8);
        bus.load_dcard3 = 1'b1;
        tick();
        clear_loads();
        n_checks++; if (bus.dcard3 !== 4'd10) begin n_fail++; $display("FAIL over_second got %0d exp 10", bus.dcard3); end
        n_checks++; if (bus.dscore !== 4'd0) begin n_fail++; $display("FAIL over_dscore got %0d exp 0", bus.dscore); end
    endtask

    task automatic test_mid_hand_reset();
        do_reset();
        bus.load_pcard1 = 1'b1; tick(); clear_loads();
        bus.load_pcard2 = 1'b1; tick(); clear_loads();
        bus.load_dcard1 = 1'b1; tick(); clear_loads();
        bus.load_dcard2 = 1'b1; tick(); clear_loads();
        bus.load_pcard3 = 1'b1; tick(); clear_loads();
        n_checks++; if (bus.pscore !== 4'd8) begin n_fail++; $display("FAIL hand_pscore got %0d exp 8", bus.pscore); end
        n_checks++; if (bus.dscore !== 4'd7) begin n_fail++; $display("FAIL hand_dscore got %0d exp 7", bus.dscore); end
        reset = 1'b1;
        bus.load_dcard3 = 1'b1;
        tick();
        reset = 1'b0;
        clear_loads();
        n_checks++; if (bus.pcard1 !== 4'd0) begin n_fail++; $display("FAIL midrst_pcard1 got %0d exp 0", bus.pcard1); end
        n_checks++; if (bus.pcard3 !== 4'd0) begin n_fail++; $display("FAIL midrst_pcard3 got %0d exp 0", bus.pcard3); end
        n_checks++; if (bus.dcard2 !== 4'd0) begin n_fail++; $display("FAIL midrst_dcard2 got %0d exp 0", bus.dcard2); end
        n_checks++; if (bus.dcard3 !== 4'd0) begin n_fail++; $display("FAIL midrst_dcard3 got %0d exp 0", bus.dcard3); end
        n_checks++; if (bus.pscore !== 4'd0) begin n_fail++; $display("FAIL midrst_pscore got %0d exp 0", bus.pscore); end
        n_checks++; if (bus.dscore !== 4'd0) begin n_fail++; $display("FAIL midrst_dscore got %0d exp 0", bus.dscore); end
        n_checks++; if (bus.deal_card !== 4'd1) begin n_fail++; $display("FAIL midrst_deal got %0d exp 1", bus.deal_card); end
        tick();
        n_checks++; if (bus.dcard3 !== 4'd0) begin n_fail++; $display("FAIL midrst_hold got %0d exp 0", bus.dcard3); end
        n_checks++; if (bus.deal_card !== 4'd2) begin n_fail++; $display("FAIL midrst_deal2 got %0d exp 2", bus.deal_card); end
    endtask

    initial begin
        clear_loads();
        idle(2);
        test_reset();
        test_first_card();
        test_two_cards();
        test_wrap();
        test_third_card();
        test_simultaneous();
        test_overwrite();
        test_mid_hand_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
